mod13_count_monitor: RTL and testbench

- Downstream checker and statistics stage for the mod-13 up/down counter.
- Taps the counter's control inputs (load, mode, data_in) and its count output.
- Keeps a shadow model of the counter and reports per-direction wrap events, saturating wrap totals, illegal count values (>12) and model mismatches.
- Enters a sticky FAULT state on a mismatch; software clears it.

---
 rtl/mod13_pkg.sv | 34 +++
 rtl/mod13_count_monitor_if.sv | 28 ++
 rtl/mod13_next_calc.sv | 13 +
 rtl/mod13_count_monitor.sv | 100 ++++++++++
 tb/tb_mod13_count_monitor.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/mod13_pkg.sv
// rtl/mod13_pkg.sv - shared types and next-count rule for the mod-13 counter and its monitor
package mod13_pkg;

    localparam int MOD_MAX = 12;
    localparam logic [3:0] MOD_MAX4 = 4'(MOD_MAX);

    typedef enum logic [1:0] {
        OP_RESET = 2'd0,
        OP_LOAD  = 2'd1,
        OP_UP    = 2'd2,
        OP_DN    = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    // Out-of-range values (13..15) step by plain +/-1 so the monitor can follow an illegal load.
    function automatic logic [3:0] next_count(op_t op, logic [3:0] cnt, logic [3:0] data);
        logic [3:0] r;
        r = 4'd0;
        case (op)
            OP_RESET: r = 4'd0;
            OP_LOAD:  r = data;
            OP_UP:    r = (cnt == MOD_MAX4) ? 4'd0 : cnt + 4'd1;
            OP_DN:    r = (cnt == 4'd0) ? MOD_MAX4 : cnt - 4'd1;
            default:  r = 4'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mod13_count_monitor_if.sv
// rtl/mod13_count_monitor_if.sv - counter taps and monitor status bundle
interface mod13_count_monitor_if #(parameter int WRAP_W = 8);

    logic                 clr;
    logic                 cnt_load;
    logic                 cnt_mode;
    logic [3:0]           cnt_data;
    logic [3:0]           count;
    logic                 wrap_up;
    logic                 wrap_dn;
    logic [WRAP_W-1:0]    up_wraps;
    logic [WRAP_W-1:0]    dn_wraps;
    logic                 illegal;
    logic                 mismatch;
    logic                 fault;
    mod13_pkg::state_t    state;

    modport master (
        output clr, cnt_load, cnt_mode, cnt_data, count,
        input  wrap_up, wrap_dn, up_wraps, dn_wraps, illegal, mismatch, fault, state
    );

    modport slave (
        input  clr, cnt_load, cnt_mode, cnt_data, count,
        output wrap_up, wrap_dn, up_wraps, dn_wraps, illegal, mismatch, fault, state
    );

endinterface

// File: rtl/mod13_next_calc.sv
// rtl/mod13_next_calc.sv - combinational predictor of the counter value after the last op
module mod13_next_calc
    import mod13_pkg::*;
(
    input  op_t        prev_op,
    input  logic [3:0] prev_count,
    input  logic [3:0] prev_data,
    output logic [3:0] expected
);

    assign expected = next_count(prev_op, prev_count, prev_data);

endmodule

// File: rtl/mod13_count_monitor.sv
// rtl/mod13_count_monitor.sv - shadow-model checker and wrap statistics for the mod-13 counter
module mod13_count_monitor
    import mod13_pkg::*;
#(
    parameter int WRAP_W  = 8,
    parameter int MOD_MAX = mod13_pkg::MOD_MAX
) (
    input  logic clk,
    input  logic rst,
    mod13_count_monitor_if.slave bus
);

    localparam logic [3:0]        TOP     = 4'(MOD_MAX);
    localparam logic [WRAP_W-1:0] SAT     = {WRAP_W{1'b1}};
    localparam logic [WRAP_W-1:0] ONE     = WRAP_W'(1);

    op_t        prev_op;
    logic [3:0] prev_count;
    logic [3:0] prev_data;
    logic [3:0] expected;
    state_t     state_q;
    state_t     state_d;

    logic mis;
    logic ill;
    logic wu_ev;
    logic wd_ev;
    logic live;

    mod13_next_calc u_next (
        .prev_op    (prev_op),
        .prev_count (prev_count),
        .prev_data  (prev_data),
        .expected   (expected)
    );

    // Capture the op the counter applies at this edge; its result is checked one edge later.
    always_ff @(posedge clk) begin
        if (rst)               prev_op <= OP_RESET;
        else if (bus.cnt_load) prev_op <= OP_LOAD;
        else if (bus.cnt_mode) prev_op <= OP_UP;
        else                   prev_op <= OP_DN;
        prev_count <= bus.count;
        prev_data  <= bus.cnt_data;
    end

    always_comb begin
        mis   = (bus.count != expected);
        ill   = (bus.count > TOP);
        wu_ev = (prev_op == OP_UP) && (prev_count == TOP) && (bus.count == 4'd0) && !mis;
        wd_ev = (prev_op == OP_DN) && (prev_count == 4'd0) && (bus.count == TOP) && !mis;
        live  = (state_q != FAULT) && !bus.clr;
    end

    always_comb begin
        state_d = state_q;
        if (bus.clr) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = mis ? FAULT : TRACK;
                TRACK:   if (mis) state_d = FAULT;
                FAULT:   state_d = FAULT;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.wrap_up  <= 1'b0;
            bus.wrap_dn  <= 1'b0;
            bus.illegal  <= 1'b0;
            bus.mismatch <= 1'b0;
            bus.up_wraps <= '0;
            bus.dn_wraps <= '0;
        end else begin
            bus.wrap_up  <= wu_ev && live;
            bus.wrap_dn  <= wd_ev && live;
            bus.illegal  <= ill;
            bus.mismatch <= mis && !bus.clr;
            if (bus.clr) begin
                bus.up_wraps <= '0;
                bus.dn_wraps <= '0;
            end else begin
                if (wu_ev && live && bus.up_wraps != SAT) bus.up_wraps <= bus.up_wraps + ONE;
                if (wd_ev && live && bus.dn_wraps != SAT) bus.dn_wraps <= bus.dn_wraps + ONE;
            end
        end
    end

    assign bus.state = state_q;
    assign bus.fault = (state_q == FAULT);

endmodule

// File: tb/tb_mod13_count_monitor.sv
// tb/tb_mod13_count_monitor.sv - scoreboard bench driving two monitor instances (WRAP_W 8 and 2)
module tb_mod13_count_monitor;
    import mod13_pkg::*;

    logic clk;
    logic rst;

    mod13_count_monitor_if #(.WRAP_W(8)) if8 ();
    mod13_count_monitor_if #(.WRAP_W(2)) if2 ();

    mod13_count_monitor #(.WRAP_W(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
    mod13_count_monitor #(.WRAP_W(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       wu;
        logic       wd;
        logic       il;
        logic       mm;
        logic       ft;
        logic [1:0] st;
        logic [7:0] u8;
        logic [7:0] d8;
        logic [1:0] u2;
        logic [1:0] d2;
    } exp_t;

    exp_t sb[$];

    int errors = 0;
    int checks = 0;

    logic [3:0] ctr = 4'd0;
    op_t        m_op = OP_RESET;
    logic [3:0] m_pc = 4'd0;
    logic [3:0] m_pd = 4'd0;
    state_t     m_st = IDLE;
    logic [7:0] m_u8 = 8'd0;
    logic [7:0] m_d8 = 8'd0;
    logic [1:0] m_u2 = 2'd0;
    logic [1:0] m_d2 = 2'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic rv, input logic lv, input logic mv, input logic [3:0] dv,
                        input logic cv, input int ovr = -1);
        logic [3:0] shown;
        logic [3:0] ev;
        logic       mis, ill, wu, wd;
        op_t        op;
        exp_t       e;
        exp_t       got;
        logic [22:0] obs8;
        logic [10:0] obs2;

        @(negedge clk);
        shown = (ovr >= 0) ? ovr[3:0] : ctr;
        rst = rv;
        if8.cnt_load = lv; if8.cnt_mode = mv; if8.cnt_data = dv; if8.clr = cv; if8.count = shown;
        if2.cnt_load = lv; if2.cnt_mode = mv; if2.cnt_data = dv; if2.clr = cv; if2.count = shown;

        e = '0;
        if (rv) begin
            m_st = IDLE;
            m_u8 = 0; m_d8 = 0; m_u2 = 0; m_d2 = 0;
        end else begin
            ev  = next_count(m_op, m_pc, m_pd);
            mis = (shown != ev);
            ill = (shown > 4'd12);
            wu  = (m_op == OP_UP) && (m_pc == 4'd12) && (shown == 4'd0) && !mis;
            wd  = (m_op == OP_DN) && (m_pc == 4'd0) && (shown == 4'd12) && !mis;
            e.il = ill;
            if (cv) begin
                m_st = IDLE;
                m_u8 = 0; m_d8 = 0; m_u2 = 0; m_d2 = 0;
            end else begin
                if (m_st != FAULT) begin
                    e.wu = wu;
                    e.wd = wd;
                    if (wu && m_u8 != 8'hff) m_u8 = m_u8 + 8'd1;
                    if (wd && m_d8 != 8'hff) m_d8 = m_d8 + 8'd1;
                    if (wu && m_u2 != 2'd3)  m_u2 = m_u2 + 2'd1;
                    if (wd && m_d2 != 2'd3)  m_d2 = m_d2 + 2'd1;
                end
                e.mm = mis;
                if (mis) m_st = FAULT;
                else if (m_st == IDLE) m_st = TRACK;
            end
        end
        e.st = m_st;
        e.ft = (m_st == FAULT);
        e.u8 = m_u8; e.d8 = m_d8; e.u2 = m_u2; e.d2 = m_d2;
        sb.push_back(e);

        op = rv ? OP_RESET : (lv ? OP_LOAD : (mv ? OP_UP : OP_DN));
        m_op = op; m_pc = shown; m_pd = dv;

        @(posedge clk);
        ctr = next_count(op, ctr, dv);
        #1;
        got = sb.pop_front();
        obs8 = {if8.wrap_up, if8.wrap_dn, if8.illegal, if8.mismatch, if8.fault, if8.state,
                if8.up_wraps, if8.dn_wraps};
        obs2 = {if2.wrap_up, if2.wrap_dn, if2.illegal, if2.mismatch, if2.fault, if2.state,
                if2.up_wraps, if2.dn_wraps};
        checks++;
        assert (obs8 === {got.wu, got.wd, got.il, got.mm, got.ft, got.st, got.u8, got.d8}) else begin
            errors++;
            $error("FAIL sb_w8 observed=%h expected=%h",
                   obs8, {got.wu, got.wd, got.il, got.mm, got.ft, got.st, got.u8, got.d8});
        end
        checks++;
        assert (obs2 === {got.wu, got.wd, got.il, got.mm, got.ft, got.st, got.u2, got.d2}) else begin
            errors++;
            $error("FAIL sb_w2 observed=%h expected=%h",
                   obs2, {got.wu, got.wd, got.il, got.mm, got.ft, got.st, got.u2, got.d2});
        end
    endtask

    initial begin
        rst = 1'b1;
        if8.clr = 0; if8.cnt_load = 0; if8.cnt_mode = 1; if8.cnt_data = 0; if8.count = 0;
        if2.clr = 0; if2.cnt_load = 0; if2.cnt_mode = 1; if2.cnt_data = 0; if2.count = 0;

        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        chk("reset_state", 32'(if8.state), 0);
        chk("reset_fault", 32'(if8.fault), 0);
        chk("reset_up_wraps", 32'(if8.up_wraps), 0);

        // Count up 0..12,0: one wrap, IDLE->TRACK
        for (int i = 0; i < 14; i++) step(0, 0, 1, 0, 0);
        chk("up_wrap_pulse", 32'(if8.wrap_up), 1);
        chk("up_wraps_one", 32'(if8.up_wraps), 1);
        chk("state_track", 32'(if8.state), 1);

        // Down from 0 wraps to 12, then 12->11 no pulse
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("dn_wrap_pulse", 32'(if8.wrap_dn), 1);
        step(0, 0, 0, 0, 0);
        chk("dn_no_pulse_12_11", 32'(if8.wrap_dn), 0);
        chk("dn_wraps_one", 32'(if8.dn_wraps), 1);

        // Illegal load of 13 then up through 15->0
        step(0, 1, 1, 4'd13, 0);
        step(0, 0, 1, 0, 0);
        chk("illegal_13", 32'(if8.illegal), 1);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
        chk("no_wrap_15_0", 32'(if8.up_wraps), 0);
        chk("no_fault_illegal", 32'(if8.fault), 0);

        // Five up wraps: narrow total saturates
        for (int i = 0; i < 65; i++) step(0, 0, 1, 0, 0);
        chk("up_wraps_w8_five", 32'(if8.up_wraps), 5);
        chk("up_wraps_w2_sat", 32'(if2.up_wraps), 3);

        // clr on the same edge as a wrap
        for (int i = 0; i < 11; i++) step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 1);
        chk("clr_wrap_suppressed", 32'(if8.wrap_up), 0);
        chk("clr_up_wraps_w8", 32'(if8.up_wraps), 0);
        chk("clr_up_wraps_w2", 32'(if2.up_wraps), 0);

        // Forced mismatch, then a frozen wrap while in FAULT
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0, int'(ctr + 4'd1));
        chk("mismatch_pulse", 32'(if8.mismatch), 1);
        chk("fault_set", 32'(if8.fault), 1);
        chk("state_fault", 32'(if8.state), 2);
        for (int i = 0; i < 14; i++) step(0, 0, 1, 0, 0);
        chk("fault_frozen_wraps", 32'(if8.up_wraps), 0);
        step(0, 0, 1, 0, 1);
        chk("clr_state_idle", 32'(if8.state), 0);
        chk("clr_fault", 32'(if8.fault), 0);

        // Reset mid-count at 7
        for (int i = 0; i < 16 && ctr != 4'd7; i++) step(0, 0, 1, 0, 0);
        chk("reached_7", 32'(ctr), 7);
        step(1, 0, 1, 0, 0);
        chk("midrst_mismatch", 32'(if8.mismatch), 0);
        chk("midrst_state", 32'(if8.state), 0);
        step(0, 0, 1, 0, 0);
        chk("post_rst_no_mismatch", 32'(if8.mismatch), 0);
        chk("post_rst_track", 32'(if8.state), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
